// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external up/down counter through a programmed
// number of lo->hi->lo sweeps, with a hold (dwell) at each turnaround.
// The counter follows enable/direction and its new value returns on count_in
// one cycle later, so enable is dropped in the same cycle a limit is seen.
module counter_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] lo_limit,
    input  logic [6:0] hi_limit,
    input  logic [3:0] dwell,
    input  logic [3:0] n_sweeps,
    input  logic [6:0] count_in,
    output logic       enable,
    output logic       direction,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] sweeps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] lo_q, lo_d;
    logic [6:0] hi_q, hi_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic [3:0] sweeps_q, sweeps_d;
    logic       dir_q, dir_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // State and program registers; reset clears everything back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            dwell_q  <= '0;
            dcnt_q   <= '0;
            sweeps_q <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            sweeps_q <= sweeps_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state and counter-enable logic; stop overrides any limit match.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        sweeps_d = sweeps_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        enable   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (lo_limit < hi_limit) begin
                        lo_d     = lo_limit;
                        hi_d     = hi_limit;
                        dwell_d  = dwell;
                        sweeps_d = n_sweeps;
                        dcnt_d   = '0;
                        // Pre-set the direction so the first ALIGN cycle
                        // already moves toward lo.
                        dir_d    = (count_in < lo_limit);
                        state_d  = S_ALIGN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ALIGN: begin
                if (count_in == lo_q) begin
                    dir_d   = 1'b1;
                    state_d = S_UP;
                end else begin
                    enable = 1'b1;
                    dir_d  = (count_in < lo_q);
                end
            end
            S_UP: begin
                if (count_in == hi_q) begin
                    dcnt_d  = '0;
                    state_d = S_DWELL_HI;
                end else begin
                    enable = 1'b1;
                end
            end
            S_DWELL_HI: begin
                if (dcnt_q == dwell_q) begin
                    dcnt_d  = '0;
                    dir_d   = 1'b0;
                    state_d = S_DOWN;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            S_DOWN: begin
                if (count_in == lo_q) begin
                    dcnt_d  = '0;
                    state_d = S_DWELL_LO;
                end else begin
                    enable = 1'b1;
                end
            end
            S_DWELL_LO: begin
                if (dcnt_q == dwell_q) begin
                    dcnt_d   = '0;
                    // A loaded 0 means 16 sweeps: 0 wraps to 15 and carries on.
                    sweeps_d = sweeps_q - 4'd1;
                    if (sweeps_q == 4'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        dir_d   = 1'b1;
                        state_d = S_UP;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop && (state_q != S_IDLE)) begin
            enable   = 1'b0;
            state_d  = S_IDLE;
            sweeps_d = '0;
            dcnt_d   = '0;
            dir_d    = dir_q;
            done_d   = 1'b0;
        end

        // Keep the counter frozen in the very cycle reset is applied.
        if (rst) begin
            enable = 1'b0;
        end
    end

    assign direction   = dir_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign sweeps_left = sweeps_q;

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a sweep program; sampled only in IDLE.
REQ-005 stop  input  1  abort request; honoured in every state except IDLE.
REQ-006 lo_limit  input  7  lower sweep bound; latched on accepted start.
REQ-007 hi_limit  input  7  upper sweep bound; latched on accepted start.
REQ-008 dwell  input  4  turnaround hold length; latched on accepted start.
REQ-009 n_sweeps  input  4  number of lo->hi->lo sweeps; latched on accepted start; 0 means 16.
REQ-010 count_in  input  7  current value of the controlled up/down counter.
REQ-011 enable  output  1  counter enable, combinational.
REQ-012 direction  output  1  counter direction, 1=up, 0=down, registered.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on normal program completion.
REQ-015 err  output  1  one-cycle pulse when start is rejected for lo_limit >= hi_limit.
REQ-016 sweeps_left  output  4  remaining sweeps, including the current sweep.

Function
REQ-017 The controlled counter advances by 1 per clock while enable=1, in the direction given by direction, and its new value is visible on count_in one cycle later.
REQ-018 The state machine SHALL have the states IDLE, ALIGN, UP, DWELL_HI, DOWN and DWELL_LO.
REQ-019 IDLE: start=1 with lo_limit < hi_limit SHALL latch lo, hi, dwell and n_sweeps, then go to ALIGN.
REQ-020 IDLE: start=1 with lo_limit >= hi_limit SHALL pulse err for one cycle and stay in IDLE.
REQ-021 ALIGN: enable=(count_in!=lo); direction=(count_in<lo); when count_in==lo the block SHALL go to UP with direction=1.
REQ-022 UP: enable=(count_in!=hi); direction=1; when count_in==hi the block SHALL go to DWELL_HI.
REQ-023 DOWN: enable=(count_in!=lo); direction=0; when count_in==lo the block SHALL go to DWELL_LO.
REQ-024 DWELL_HI and DWELL_LO SHALL hold enable=0 for exactly dwell+1 cycles, so dwell=0 gives a one-cycle turnaround.
REQ-025 On leaving DWELL_HI the block SHALL go to DOWN with direction=0.
REQ-026 On leaving DWELL_LO, sweeps_left SHALL decrement. If it was 1, the block SHALL pulse done and go to IDLE; otherwise it SHALL go to UP with direction=1.
REQ-027 enable SHALL be 0 in IDLE, in DWELL states, and in any cycle where stop=1, so the counter never overshoots a limit or moves after an abort.
REQ-028 stop=1 outside IDLE SHALL force the next state to IDLE; done SHALL NOT pulse; sweeps_left SHALL clear to 0.
REQ-029 If stop and a limit match occur in the same cycle, stop SHALL win.
REQ-030 start while busy SHALL be ignored.
REQ-031 Changes to the limit, dwell and n_sweeps inputs while busy SHALL have no effect.
REQ-032 direction SHALL hold its last value in IDLE and DWELL states.
REQ-033 n_sweeps=0 SHALL load sweeps_left=0, interpreted as 16, and decrement with 4-bit wrap; completion occurs when the pre-decrement value is 1.
REQ-034 Limits 0 and 127 SHALL be legal; the counter never wraps because enable drops at a limit.

Reset
REQ-035 While rst=1, the block SHALL go to IDLE, with enable=0, direction=0, busy=0, done=0, err=0, sweeps_left=0, and latched limits, dwell and dwell counter cleared.
REQ-036 rst asserted mid-program SHALL abort with no done pulse; rst SHALL take priority over start and stop.

Verification
REQ-037 Scenario 1: count_in=0, start with lo=2, hi=5, dwell=0, n=1 -> ALIGN counts up 0->2; UP 2->5; DWELL_HI 1 cycle; DOWN 5->2; DWELL_LO 1 cycle; done pulses once; count_in never leaves 0..5.
REQ-038 Scenario 2: count_in=10, start with lo=3, hi=6 -> ALIGN with direction=0 down to 3, then direction=1 up.
REQ-039 Scenario 3: start with lo=5, hi=5 -> err pulses for 1 cycle; busy stays 0; enable stays 0.
REQ-040 Scenario 4: dwell=3, n=2 -> each dwell lasts 4 cycles with enable=0; sweeps_left goes 2->1->0; done follows the second DWELL_LO.
REQ-041 Scenario 5: stop during UP at count_in=4 -> enable=0 in the same cycle; IDLE next cycle; count_in holds 4; no done pulse.
REQ-042 Scenario 6: rst mid-DOWN -> all outputs at reset values the next cycle; a later start with lo=0, hi=127 sweeps the full range with no wrap.
